led_scan_sched: RTL and testbench
=================================

Name: led_scan_sched

Overview:
- Scan scheduler for the 16x16 LED matrix. Owns column sequencing, inter-column blanking, a double-buffered frame store and scroll offset.
- Upstream content generators (name/number pattern logic) write 16-bit column words into the back bank and request a bank swap. The block swaps only at a frame boundary, so the display never tears.
- Outputs drive the matrix column (one-hot, active-high) and row (active-low) pins directly.

Parameters:
- DWELL_CYC, 5000, clock cycles each column is driven (10 kHz column rate at 50 MHz).
- BLANK_CYC, 50, clock cycles of all-off blanking before each column (anti-ghosting); minimum 1.
- SCROLL_FRAMES, 62, frames per scroll step of one column.

Ports:
- CLK_50MHz  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write strobe into back bank.
- wr_addr  in  4  column index written.
- wr_data  in  16  column word; bit=1 means LED on.
- swap_req  in  1  single-cycle pulse requesting front/back swap.
- swap_ack  out  1  single-cycle pulse when swap is performed.
- scroll_en  in  1  enable horizontal scrolling.
- frame_done  out  1  single-cycle pulse at end of column 15 drive.
- column  out  16  one-hot column select.
- row  out  16  active-low row data.

Behaviour:
- One clock (CLK_50MHz); reset is asynchronous, active-high (RST). All outputs registered.
- Reset values: column=16'h0000, row=16'hFFFF, swap_ack=0, frame_done=0. State=BLANK, col_idx=0, cycle counter=0, offset=0, disp_bank=0, swap_pending=0. Both banks are cleared to 16'h0000.
- FSM, two states:
  - BLANK: outputs column=0, row=FFFF. After BLANK_CYC cycles go to DRIVE.
  - DRIVE: column=1<<col_idx, row=~bank[disp_bank][(col_idx+offset) mod 16]. After DWELL_CYC cycles return to BLANK and increment col_idx (mod 16).
- Outputs change on the clock edge after a state transition: one-cycle latency from state to pins.
- Frame end is the last DRIVE cycle with col_idx=15. That cycle asserts frame_done the following cycle.
- Swap handling:
  - A swap_req pulse sets swap_pending.
  - At frame end with swap_pending=1 (including a swap_req arriving that same cycle): toggle disp_bank, pulse swap_ack with frame_done, and clear pending.
  - Multiple requests within one frame collapse into a single swap.
- Writes always target bank ~disp_bank as sampled in the write cycle. A write coinciding with the swap edge therefore lands in the bank becoming displayed; upstream must avoid this by waiting for swap_ack. Writes to the front bank are impossible.
- Scroll:
  - A frame counter counts frame ends while scroll_en=1.
  - On reaching SCROLL_FRAMES: offset increments (4-bit wrap, 15 goes to 0) and the counter clears.
  - Offset changes only at frame ends.
  - scroll_en=0 holds both offset and counter (neither cleared).
- Counters are sized $clog2 of their maximum parameter value; no arithmetic overflow is possible.
- RST mid-frame: immediate blank outputs; frame contents are lost.

Optional Feature:
- Macro: LED_SCAN_BRIGHT_EN.
- With the macro: adds input bright[2:0]. During DRIVE, row data is shown for the first ((bright+1)*DWELL_CYC)>>3 cycles, then row=FFFF for the rest of the dwell while column stays asserted. bright is sampled at BLANK->DRIVE entry. bright=7 gives the full dwell.
- Without the macro: no port; row is valid for the entire dwell.

Decomposition:
- Package led_pkg holds:
  - constants LED_COLS=16, LED_ROWS=16;
  - typedefs col_idx_t (4-bit) and row_word_t (16-bit);
  - enum scan_state_t {BLANK, DRIVE}.
- Sub-module led_frame_buf: dual-bank 16x16 register array with one write port (back bank) and one combinational read port (front bank). Bank select is an input.

Test Plan (DWELL_CYC=8, BLANK_CYC=2, SCROLL_FRAMES=2):
- Reset released -> column=0000/row=FFFF for 2 cycles, then column=0001/row=FFFF (bank clear) for 8 cycles, then 2 blank cycles, then column=0002; frame_done once every 160 cycles.
- Write col3=16'h00FC to back bank, then swap_req -> swap_ack coincides with frame_done. In the next frame, the column=0008 dwell shows row=FF03.
- swap_req pulsed 3 times in one frame -> exactly one swap_ack; bank toggles once.
- swap_req on the exact frame-end cycle -> swap happens at that boundary, no one-frame delay.
- scroll_en=1 with col0=0001, others 0 -> offset becomes 1 after 2 frames, and row=FFFE appears at column=8000. After 32 frames offset wraps back to 0.
- Assert RST mid-DRIVE of col 7 -> column=0000, row=FFFF immediately, asynchronously. After release, the scan restarts at col 0 with cleared banks.

Source files
------------

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and types for the LED matrix scan scheduler
package led_pkg;

    localparam int LED_COLS = 16;
    localparam int LED_ROWS = 16;

    typedef logic [3:0]          col_idx_t;
    typedef logic [LED_ROWS-1:0] row_word_t;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/led_frame_buf.sv
// rtl/led_frame_buf.sv - dual-bank 16x16 frame store, one write port, one combinational read port
module led_frame_buf
    import led_pkg::*;
(
    input  logic      CLK_50MHz,
    input  logic      RST,
    input  logic      wr_en,
    input  logic      wr_bank,
    input  col_idx_t  wr_addr,
    input  row_word_t wr_data,
    input  logic      rd_bank,
    input  col_idx_t  rd_addr,
    output row_word_t rd_data
);

    row_word_t mem [2][LED_COLS];

    // Column word storage; reset blanks both banks so a fresh scan shows nothing
    always_ff @(posedge CLK_50MHz or posedge RST) begin
        if (RST) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < LED_COLS; c++) begin
                    mem[b][c] <= '0;
                end
            end
        end else if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/led_scan_sched.sv
// rtl/led_scan_sched.sv - column scan, blanking, bank swap and scroll for the 16x16 LED matrix (option: LED_SCAN_BRIGHT_EN)
module led_scan_sched
    import led_pkg::*;
#(
    parameter int DWELL_CYC     = 5000,
    parameter int BLANK_CYC     = 50,
    parameter int SCROLL_FRAMES = 62
) (
    input  logic      CLK_50MHz,
    input  logic      RST,
    input  logic      wr_en,
    input  col_idx_t  wr_addr,
    input  row_word_t wr_data,
    input  logic      swap_req,
    output logic      swap_ack,
    input  logic      scroll_en,
`ifdef LED_SCAN_BRIGHT_EN
    input  logic [2:0] bright,
`endif
    output logic      frame_done,
    output row_word_t column,
    output row_word_t row
);

    localparam int CYC_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CW      = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam int FW      = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    scan_state_t state, state_nxt;
    logic [CW-1:0] cyc, cyc_nxt;
    col_idx_t      col_idx, col_nxt;
    logic          frame_end;
    logic          swap_now;

    logic          disp_bank;
    logic          swap_pending;
    col_idx_t      offset;
    logic [FW-1:0] frame_cnt;

    row_word_t     rd_data;
    logic          row_on;

    led_frame_buf u_frame_buf (
        .CLK_50MHz (CLK_50MHz),
        .RST       (RST),
        .wr_en     (wr_en),
        .wr_bank   (~disp_bank),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_bank   (disp_bank),
        .rd_addr   (col_idx + offset),
        .rd_data   (rd_data)
    );

    // Scan state register: phase, cycle-in-phase and current column
    always_ff @(posedge CLK_50MHz or posedge RST) begin
        if (RST) begin
            state   <= BLANK;
            cyc     <= '0;
            col_idx <= '0;
        end else begin
            state   <= state_nxt;
            cyc     <= cyc_nxt;
            col_idx <= col_nxt;
        end
    end

    // Next-state: blank gap, then dwell; the final dwell cycle of column 15 ends the frame
    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc + 1'b1;
        col_nxt   = col_idx;
        frame_end = 1'b0;
        case (state)
            BLANK: begin
                if (cyc == CW'(BLANK_CYC - 1)) begin
                    state_nxt = DRIVE;
                    cyc_nxt   = '0;
                end
            end
            DRIVE: begin
                if (cyc == CW'(DWELL_CYC - 1)) begin
                    state_nxt = BLANK;
                    cyc_nxt   = '0;
                    col_nxt   = col_idx + 1'b1;
                    frame_end = (col_idx == col_idx_t'(LED_COLS - 1));
                end
            end
            default: begin
                state_nxt = BLANK;
                cyc_nxt   = '0;
            end
        endcase
    end

    // A request arriving on the frame-end cycle itself is honoured at that boundary
    assign swap_now = frame_end & (swap_pending | swap_req);

    // Bank swap bookkeeping; any number of requests in a frame collapse into one swap
    always_ff @(posedge CLK_50MHz or posedge RST) begin
        if (RST) begin
            disp_bank    <= 1'b0;
            swap_pending <= 1'b0;
        end else if (swap_now) begin
            disp_bank    <= ~disp_bank;
            swap_pending <= 1'b0;
        end else if (swap_req) begin
            swap_pending <= 1'b1;
        end
    end

    // Scroll: count enabled frame ends, step the column offset every SCROLL_FRAMES of them
    always_ff @(posedge CLK_50MHz or posedge RST) begin
        if (RST) begin
            frame_cnt <= '0;
            offset    <= '0;
        end else if (frame_end && scroll_en) begin
            if (frame_cnt == FW'(SCROLL_FRAMES - 1)) begin
                frame_cnt <= '0;
                offset    <= offset + 1'b1;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

`ifdef LED_SCAN_BRIGHT_EN
    logic [2:0]  bright_q;
    logic [31:0] on_cycles;

    // Latch brightness as the dwell starts so it cannot change mid-column
    always_ff @(posedge CLK_50MHz or posedge RST) begin
        if (RST) begin
            bright_q <= 3'd7;
        end else if (state == BLANK && state_nxt == DRIVE) begin
            bright_q <= bright;
        end
    end

    assign on_cycles = ((32'(bright_q) + 32'd1) * 32'(DWELL_CYC)) >> 3;
    assign row_on    = (32'(cyc) < on_cycles);
`else
    assign row_on = 1'b1;
`endif

    // Registered pins: one cycle behind the scan state so nothing glitches at the matrix
    always_ff @(posedge CLK_50MHz or posedge RST) begin
        if (RST) begin
            column     <= '0;
            row        <= '1;
            frame_done <= 1'b0;
            swap_ack   <= 1'b0;
        end else begin
            column     <= (state == DRIVE) ? (row_word_t'(1) << col_idx) : '0;
            row        <= (state == DRIVE && row_on) ? ~rd_data : '1;
            frame_done <= frame_end;
            swap_ack   <= swap_now;
        end
    end

endmodule

// File: tb/tb_led_scan_sched.sv
// tb/tb_led_scan_sched.sv - randomized and directed checks of led_scan_sched against a frame-arithmetic model
module tb_led_scan_sched;

    localparam int DW = 8;
    localparam int BL = 2;
    localparam int SF = 2;
    localparam int P  = DW + BL;
    localparam int F  = 16 * P;

    logic        CLK_50MHz = 1'b0;
    logic        RST;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        swap_req;
    logic        swap_ack;
    logic        scroll_en;
    logic        frame_done;
    logic [15:0] column;
    logic [15:0] row;

    int vectors;
    int miscompares;

    // model state: scan index since reset release, banks, swap and scroll bookkeeping
    int          mn;
    logic [15:0] mbank [2][16];
    int          mdisp, mpend, moff, mfcnt;
    logic [15:0] e_col, e_row;
    logic        e_fd, e_ack;

    always #10 CLK_50MHz = ~CLK_50MHz;

    led_scan_sched #(
        .DWELL_CYC     (DW),
        .BLANK_CYC     (BL),
        .SCROLL_FRAMES (SF)
    ) dut (
        .CLK_50MHz  (CLK_50MHz),
        .RST        (RST),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .scroll_en  (scroll_en),
`ifdef LED_SCAN_BRIGHT_EN
        .bright     (3'd7),
`endif
        .frame_done (frame_done),
        .column     (column),
        .row        (row)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mn = 0; mdisp = 0; mpend = 0; moff = 0; mfcnt = 0;
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < 16; c++)
                mbank[b][c] = 16'h0000;
    endtask

    // Expected pins after an edge come from where the scan was during the cycle that just ended
    task automatic model_edge();
        int p, c, w;
        bit drv, fe;
        if (RST) begin
            model_reset();
            e_col = 16'h0000; e_row = 16'hFFFF; e_fd = 1'b0; e_ack = 1'b0;
        end else begin
            p   = mn % F;
            c   = p / P;
            w   = p % P;
            drv = (w >= BL);
            fe  = (p == F - 1);
            e_col = drv ? (16'h0001 << c) : 16'h0000;
            e_row = drv ? ~mbank[mdisp][(c + moff) % 16] : 16'hFFFF;
            e_fd  = fe;
            e_ack = fe && (mpend != 0 || swap_req);
            if (wr_en) mbank[1 - mdisp][int'(wr_addr)] = wr_data;
            if (fe && (mpend != 0 || swap_req)) begin
                mdisp = 1 - mdisp;
                mpend = 0;
            end else if (swap_req) begin
                mpend = 1;
            end
            if (fe && scroll_en) begin
                mfcnt++;
                if (mfcnt == SF) begin
                    mfcnt = 0;
                    moff  = (moff + 1) % 16;
                end
            end
            mn++;
        end
    endtask

    task automatic step();
        @(posedge CLK_50MHz);
        model_edge();
        #1;
        check("column", column, e_col);
        check("row", row, e_row);
        check("frame_done", frame_done, e_fd);
        check("swap_ack", swap_ack, e_ack);
    endtask

    initial begin
        int fd_cnt, seen, got, acks, fcount, seen1, seen2, bad;
        vectors = 0; miscompares = 0;
        RST = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        swap_req = 1'b0; scroll_en = 1'b0;
        model_reset();
        repeat (3) step();
        check("reset_column", column, 16'h0000);
        check("reset_row", row, 16'hFFFF);
        RST = 1'b0;

        // phase 1: idle scan timing from reset
        fd_cnt = 0;
        for (int k = 1; k <= 170; k++) begin
            step();
            if (k == 2)   check("p1_col_blank", column, 16'h0000);
            if (k == 3)   check("p1_col0", column, 16'h0001);
            if (k == 3)   check("p1_row_clear", row, 16'hFFFF);
            if (k == 11)  check("p1_gap", column, 16'h0000);
            if (k == 13)  check("p1_col1", column, 16'h0002);
            if (k == 160) check("p1_fd_at_160", frame_done, 1);
            fd_cnt += int'(frame_done);
        end
        check("p1_fd_count", fd_cnt, 1);

        // phase 2: write col 3 into back bank, swap, see it displayed
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h00FC;
        step();
        wr_en = 1'b0; swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        got = 0;
        for (int k = 0; k < 400 && got == 0; k++) begin
            step();
            if (swap_ack) begin
                got = 1;
                check("p2_ack_with_fd", frame_done, 1);
            end
        end
        check("p2_ack_seen", got, 1);
        seen = 0;
        for (int k = 0; k < F; k++) begin
            step();
            if (column == 16'h0008) begin
                seen++;
                check("p2_row_col3", row, 16'hFF03);
            end
        end
        check("p2_dwell_len", seen, DW);

        // phase 3: three requests inside one frame give a single swap
        for (int k = 0; k < 2 * F && (mn % F) != 5; k++) step();
        for (int r = 0; r < 3; r++) begin
            swap_req = 1'b1;
            step();
            swap_req = 1'b0;
            repeat (20) step();
        end
        acks = 0;
        for (int k = 0; k < 2 * F; k++) begin
            step();
            acks += int'(swap_ack);
        end
        check("p3_single_ack", acks, 1);

        // phase 4: request on the exact frame-end cycle
        for (int k = 0; k < 2 * F && (mn % F) != F - 1; k++) step();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check("p4_ack_same_edge", swap_ack, 1);
        check("p4_fd_same_edge", frame_done, 1);

        // phase 5: scroll a single lit column and watch the offset walk and wrap
        for (int a = 0; a < 16; a++) begin
            wr_en = 1'b1; wr_addr = 4'(a); wr_data = (a == 0) ? 16'h0001 : 16'h0000;
            step();
        end
        wr_en = 1'b0; swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        got = 0;
        for (int k = 0; k < 2 * F && got == 0; k++) begin
            step();
            if (swap_ack) got = 1;
        end
        check("p5_swap_seen", got, 1);
        scroll_en = 1'b1;
        fcount = 0; seen1 = 0; seen2 = 0;
        for (int k = 0; k < 34 * F && fcount < 33; k++) begin
            step();
            if (fcount == 2 && column == 16'h8000) begin
                seen1++;
                check("p5_offset1_row", row, 16'hFFFE);
            end
            if (fcount == 32 && column == 16'h0001) begin
                seen2++;
                check("p5_wrap_row", row, 16'hFFFE);
            end
            fcount += int'(frame_done);
        end
        check("p5_offset1_seen", seen1, DW);
        check("p5_wrap_seen", seen2, DW);
        scroll_en = 1'b0;

        // phase 6: randomized writes, swaps and scroll toggling
        for (int k = 0; k < 3000; k++) begin
            wr_en    = ($urandom % 4) == 0;
            wr_addr  = 4'($urandom);
            wr_data  = 16'($urandom);
            swap_req = ($urandom % 97) == 0;
            if ((k % 400) == 0) scroll_en = 1'($urandom);
            step();
        end
        wr_en = 1'b0; swap_req = 1'b0; scroll_en = 1'b0;

        // phase 7: asynchronous reset in the middle of column 7 dwell
        for (int k = 0; k < 2 * F && (mn % F) != 7 * P + 5; k++) step();
        check("p7_pre_col7", column, 16'h0080);
        RST = 1'b1;
        #1;
        check("p7_async_column", column, 16'h0000);
        check("p7_async_row", row, 16'hFFFF);
        check("p7_async_fd", frame_done, 0);
        check("p7_async_ack", swap_ack, 0);
        model_reset();
        repeat (2) step();
        RST = 1'b0;
        bad = 0;
        for (int k = 1; k <= 170; k++) begin
            step();
            if (k == 3) check("p7_restart_col0", column, 16'h0001);
            if (row !== 16'hFFFF) bad++;
        end
        check("p7_banks_cleared", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
